// File: rtl/ring_gate_counter.sv
// Gated edge counter for an adder-ring oscillator: arms the ring, flushes the
// synchronizer, then counts rising edges of ring_in over a programmable window.
module ring_gate_counter (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        active,
    input  logic        start,
    input  logic [31:0] gate_cycles,
    input  logic        ring_in,
    output logic        ring_enable,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [31:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        ring_edge;
    logic [1:0]  arm_cnt;
    logic [1:0]  arm_cnt_next;
    logic [31:0] timer;
    logic [31:0] timer_next;
    logic [31:0] count_next;
    logic        overflow_next;
    logic        done_next;
    logic        finish;
    logic        finish_next;
    logic        busy_next;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ring_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ring_edge = s2 & ~s3;

    // Status outputs trail the FSM by one edge; finish carries the window end
    // into done, while busy drops on the abort edge itself.
    always_comb begin
        state_next    = state;
        arm_cnt_next  = arm_cnt;
        timer_next    = timer;
        count_next    = count;
        overflow_next = overflow;
        done_next     = done | finish;
        finish_next   = 1'b0;
        busy_next     = (state != IDLE) && active;

        case (state)
            IDLE: begin
                if (start && active && (gate_cycles != 32'd0)) begin
                    state_next    = ARM;
                    arm_cnt_next  = 2'd0;
                    timer_next    = gate_cycles;
                    count_next    = 32'd0;
                    overflow_next = 1'b0;
                    done_next     = 1'b0;
                end
            end
            ARM: begin
                if (!active) begin
                    state_next = IDLE;
                end else if (arm_cnt == 2'd2) begin
                    state_next = COUNT;
                end else begin
                    arm_cnt_next = arm_cnt + 2'd1;
                end
            end
            COUNT: begin
                if (!active) begin
                    state_next = IDLE;
                end else begin
                    if (ring_edge) begin
                        if (count == 32'hFFFF_FFFF) begin
                            overflow_next = 1'b1;
                        end else begin
                            count_next = count + 32'd1;
                        end
                    end
                    timer_next = timer - 32'd1;
                    if (timer == 32'd1) begin
                        state_next  = IDLE;
                        finish_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            arm_cnt     <= 2'd0;
            timer       <= 32'd0;
            count       <= 32'd0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            finish      <= 1'b0;
            busy        <= 1'b0;
            ring_enable <= 1'b0;
        end else begin
            state       <= state_next;
            arm_cnt     <= arm_cnt_next;
            timer       <= timer_next;
            count       <= count_next;
            overflow    <= overflow_next;
            done        <= done_next;
            finish      <= finish_next;
            busy        <= busy_next;
            ring_enable <= busy_next;
        end
    end

endmodule

// File: tb/tb_ring_gate_counter.sv
// Testbench for ring_gate_counter: table-driven measurement windows scored
// through an expected-result queue, plus abort, restart, reset and saturation cases.
module tb_ring_gate_counter;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        active;
    logic        start;
    logic [31:0] gate_cycles;
    logic        ring_in;
    logic        ring_enable;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] count;

    int checks = 0;
    int errors = 0;
    int ring_half = 0;

    typedef struct {
        logic [31:0] count;
        logic        overflow;
        int          busy_len;
    } exp_t;

    typedef struct {
        int          half;
        logic [31:0] gate;
        logic [31:0] exp_count;
        logic        exp_ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    ring_gate_counter dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .active      (active),
        .start       (start),
        .gate_cycles (gate_cycles),
        .ring_in     (ring_in),
        .ring_enable (ring_enable),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .count       (count)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    // Free-running ring model: toggles every ring_half clocks, offset from the edge.
    initial begin
        int ring_cnt;
        ring_cnt = 0;
        ring_in  = 1'b0;
        forever begin
            @(posedge wb_clk_i);
            #3;
            if (ring_half != 0) begin
                ring_cnt++;
                if (ring_cnt >= ring_half) begin
                    ring_in  = ~ring_in;
                    ring_cnt = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic applyStimulus(input logic [31:0] gate, input logic [31:0] exp_count,
                                 input logic exp_ovf);
        exp_t e;
        start       = 1'b1;
        gate_cycles = gate;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start = 1'b0;
        checkOutput("done_clear_on_start", {31'd0, done}, 32'd0);
        e.count    = exp_count;
        e.overflow = exp_ovf;
        e.busy_len = int'(gate) + 3;
        sb.push_back(e);
    endtask

    task automatic collectResult(input string name);
        exp_t e;
        int   len;
        int   t;
        int   limit;
        len = 0;
        t   = 0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
            return;
        end
        limit = sb[0].busy_len + 20;
        while (done !== 1'b1 && t < limit) begin
            if (busy === 1'b1) len++;
            @(negedge wb_clk_i);
            t++;
        end
        e = sb.pop_front();
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, t);
            return;
        end
        checkOutput({name, "_count"}, count, e.count);
        checkOutput({name, "_overflow"}, {31'd0, overflow}, {31'd0, e.overflow});
        checkOutput({name, "_busy_len"}, len, e.busy_len);
        checkOutput({name, "_idle_busy"}, {30'd0, busy, ring_enable}, 32'd0);
    endtask

    initial begin
        int rebusy;

        vecs[0] = '{2,  32'd40,  32'd10, 1'b0};
        vecs[1] = '{1,  32'd20,  32'd10, 1'b0};
        vecs[2] = '{3,  32'd60,  32'd10, 1'b0};
        vecs[3] = '{1,  32'd2,   32'd1,  1'b0};
        vecs[4] = '{0,  32'd8,   32'd0,  1'b0};
        vecs[5] = '{5,  32'd100, 32'd10, 1'b0};
        vecs[6] = '{2,  32'd4,   32'd1,  1'b0};

        wb_rst_i    = 1'b1;
        active      = 1'b1;
        start       = 1'b0;
        gate_cycles = 32'd0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        checkOutput("reset_count", count, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_ring_enable", {31'd0, ring_enable}, 32'd0);

        // A zero-length window is rejected outright.
        start       = 1'b1;
        gate_cycles = 32'd0;
        @(negedge wb_clk_i);
        start = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("zero_gate_busy", {31'd0, busy}, 32'd0);
        checkOutput("zero_gate_ring_enable", {31'd0, ring_enable}, 32'd0);
        checkOutput("zero_gate_done", {31'd0, done}, 32'd0);
        checkOutput("zero_gate_count", count, 32'd0);

        for (int i = 0; i < 7; i++) begin
            ring_half = vecs[i].half;
            repeat (20) @(negedge wb_clk_i);
            applyStimulus(vecs[i].gate, vecs[i].exp_count, vecs[i].exp_ovf);
            collectResult($sformatf("vec%0d", i));
        end

        // Inactive in IDLE: start blocked, previous result held.
        ring_half   = 2;
        active      = 1'b0;
        start       = 1'b1;
        gate_cycles = 32'd40;
        @(negedge wb_clk_i);
        start = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        checkOutput("inactive_busy", {31'd0, busy}, 32'd0);
        checkOutput("inactive_done_held", {31'd0, done}, 32'd1);
        checkOutput("inactive_count_held", count, 32'd1);
        active = 1'b1;
        repeat (20) @(negedge wb_clk_i);

        // Abort 20 cycles into a 100-cycle window.
        applyStimulus(32'd100, 32'd4, 1'b0);
        repeat (19) @(negedge wb_clk_i);
        checkOutput("abort_mid_busy", {30'd0, busy, ring_enable}, 32'd3);
        active = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ring_enable", {31'd0, ring_enable}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_count", count, 32'd4);
        active = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        checkOutput("abort_stays_idle", {30'd0, busy, done}, 32'd0);
        sb.delete();
        repeat (10) @(negedge wb_clk_i);

        // Second start mid-run with a different gate is ignored.
        applyStimulus(32'd40, 32'd10, 1'b0);
        fork
            collectResult("restart");
            begin
                repeat (9) @(negedge wb_clk_i);
                gate_cycles = 32'd5;
                start       = 1'b1;
                @(negedge wb_clk_i);
                start = 1'b0;
            end
        join
        rebusy = 0;
        repeat (50) begin
            @(negedge wb_clk_i);
            if (busy === 1'b1) rebusy++;
        end
        checkOutput("restart_no_second_run", rebusy, 0);
        checkOutput("restart_done_held", {31'd0, done}, 32'd1);

        // Reset 25 cycles into a 40-cycle run, then a clean run.
        applyStimulus(32'd40, 32'd10, 1'b0);
        repeat (24) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        sb.delete();
        checkOutput("midreset_count", count, 32'd0);
        checkOutput("midreset_flags", {28'd0, busy, ring_enable, done, overflow}, 32'd0);
        repeat (5) @(negedge wb_clk_i);
        checkOutput("midreset_stays_idle", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge wb_clk_i);
        applyStimulus(32'd40, 32'd10, 1'b0);
        collectResult("after_reset");

        // Saturation: preload near full scale during ARM, three ring edges in the window.
        repeat (10) @(negedge wb_clk_i);
        applyStimulus(32'd12, 32'hFFFF_FFFF, 1'b1);
        force dut.count = 32'hFFFF_FFFE;
        @(negedge wb_clk_i);
        release dut.count;
        collectResult("saturate");

        // The next accepted start clears the sticky overflow.
        repeat (10) @(negedge wb_clk_i);
        applyStimulus(32'd8, 32'd2, 1'b0);
        collectResult("ovf_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_gate_counter.md
RING_GATE_COUNTER -- requirements
Module: ring_gate_counter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of wb_clk_i.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- active  in  1  design-select enable; 0 forces idle/abort.
- start  in  1  single-cycle measurement request.
- gate_cycles  in  32  measurement window length in wb_clk_i cycles.
- ring_in  in  1  chain_out of the instrumented adder ring; asynchronous to wb_clk_i.
- ring_enable  out  1  enables the adder ring oscillator.
- busy  out  1  measurement in progress.
- done  out  1  sticky; result valid.
- overflow  out  1  sticky; count saturated.
- count  out  32  rising edges of ring_in seen in the window.
REQ-003 SHALL have no parameters; all widths fixed as listed.

Function
REQ-004 SHALL pass ring_in through a 2-flop synchronizer (s1, s2) plus a history flop s3; edge = s2 & ~s3.
REQ-005 SHALL implement FSM states IDLE, ARM, COUNT; all outputs SHALL be registered.
REQ-006 IDLE: ring_enable=0, busy=0; start=1 & active=1 & gate_cycles!=0 -> ARM.
REQ-007 On start acceptance: latch gate_cycles into timer; clear count, overflow and done on the same edge.
REQ-008 start with gate_cycles==0 SHALL be ignored: stay IDLE, no flags change.
REQ-009 ARM: exactly 3 cycles; ring_enable=1, busy=1; edges ignored (synchronizer flush); then -> COUNT.
REQ-010 COUNT: exactly N = latched gate_cycles cycles; ring_enable=1, busy=1; each cycle with edge=1 increments count.
REQ-011 count SHALL saturate at 0xFFFF_FFFF; an edge at saturation SHALL set overflow=1 and leave count unchanged.
REQ-012 After the Nth COUNT cycle -> IDLE with done=1, busy=0, ring_enable=0; count and overflow held until the next accepted start or reset.
REQ-013 Timing: start sampled at edge k -> busy=1 after k+1; COUNT spans edges k+4..k+3+N; done=1 after edge k+4+N.
REQ-014 start while busy=1 SHALL be ignored; the latched timer is unaffected by later gate_cycles changes.
REQ-015 active=0 in ARM or COUNT SHALL abort -> IDLE next edge: done stays 0, busy=0, ring_enable=0, count holds the partial value.
REQ-016 active=0 in IDLE SHALL block start acceptance; done, count and overflow are held.
REQ-017 The timer SHALL be a 32-bit down-counter; gate_cycles=0xFFFF_FFFF SHALL be supported without wrap.

Reset
REQ-018 wb_rst_i=1 SHALL, on the next edge and regardless of state, force:
- FSM -> IDLE.
- count=0, done=0, overflow=0, busy=0, ring_enable=0.
- timer=0.
- s1, s2, s3 = 0.
REQ-019 Reset SHALL take priority over start and active in the same cycle; a reset mid-COUNT discards the measurement.

Verification
REQ-020 Basic count: ring_in toggles every 2 clocks (one rising edge per 4 clocks), gate_cycles=40, start pulse -> busy for 43 cycles, then done=1, count=10, overflow=0.
REQ-021 Zero gate: gate_cycles=0, start pulse -> FSM stays IDLE, busy=0, done=0, count unchanged.
REQ-022 Abort: gate_cycles=100, ring_in toggles as REQ-020, active dropped 20 cycles after start -> next cycle busy=0, ring_enable=0, done=0, count=4.
REQ-023 Saturation: force count to 0xFFFF_FFFE via the bench, then 3 edges during COUNT -> count=0xFFFF_FFFF, overflow=1, done=1 at window end.
REQ-024 Start while busy: second start 10 cycles into a gate_cycles=40 run, with gate_cycles changed to 5 -> window still 40 cycles, count=10, only one done assertion.
REQ-025 Reset mid-COUNT: wb_rst_i pulsed at cycle 25 of a 40-cycle run -> all outputs 0 the next cycle; a fresh start then gives count=10.
